// File: rtl/reservation_station_add_if.sv
// Dispatch / CDB / result bus between the issue logic and one ADD/SUB reservation station.
// The master side is dispatch plus the CDB arbiter; the slave side is the station.
interface reservation_station_add_if;
  logic        Enable_VQ;
  logic [2:0]  Opcode;
  logic [15:0] Vj;
  logic [15:0] Vk;
  logic [2:0]  Qj;
  logic [2:0]  Qk;
  logic        CDB_Valid;
  logic [2:0]  CDB_Tag;
  logic [15:0] CDB_Data;
  logic        Result_Grant;
  logic        Ready;
  logic        Busy;
  logic        Result_Valid;
  logic [2:0]  Result_Tag;
  logic [15:0] Result_Data;

  modport master (
    output Enable_VQ, Opcode, Vj, Vk, Qj, Qk,
    output CDB_Valid, CDB_Tag, CDB_Data, Result_Grant,
    input  Ready, Busy, Result_Valid, Result_Tag, Result_Data
  );

  modport slave (
    input  Enable_VQ, Opcode, Vj, Vk, Qj, Qk,
    input  CDB_Valid, CDB_Tag, CDB_Data, Result_Grant,
    output Ready, Busy, Result_Valid, Result_Tag, Result_Data
  );
endinterface

// File: rtl/reservation_station_add.sv
// Single-entry ADD/SUB Tomasulo reservation station.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | free, Ready=1; captures an op when Enable_VQ and Opcode!=0
//   WAIT_OPS | op held, snooping the CDB for the still-pending operand(s)
//   EXEC     | both operands present, counting down EXEC_LATENCY cycles
//   WB       | result on Result_*, held until Result_Grant
module reservation_station_add #(
  parameter logic [2:0]  STATION_TAG  = 3'd1,
  parameter int          EXEC_LATENCY = 2,
  parameter logic [2:0]  NO_TAG       = 3'd0,
  parameter logic [15:0] NO_VALUE     = 16'hFFF0
) (
  input  logic                        Clock,
  input  logic                        Reset,
  reservation_station_add_if.slave    bus
);

  localparam logic [2:0] CNT_LOAD = 3'(EXEC_LATENCY - 1);
  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b010;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_OPS = 2'd1,
    EXEC     = 2'd2,
    WB       = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        sub_q, sub_d;
  logic [15:0] vj_q, vj_d;
  logic [15:0] vk_q, vk_d;
  logic [2:0]  qj_q, qj_d;
  logic [2:0]  qk_q, qk_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        rvalid_q, rvalid_d;
  logic [2:0]  rtag_q, rtag_d;
  logic [15:0] rdata_q, rdata_d;

  // Next-state and next-output logic for the whole station.
  always_comb begin
    state_d  = state_q;
    sub_d    = sub_q;
    vj_d     = vj_q;
    vk_d     = vk_q;
    qj_d     = qj_q;
    qk_d     = qk_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    rvalid_d = rvalid_q;
    rtag_d   = rtag_q;
    rdata_d  = rdata_q;

    case (state_q)
      IDLE: begin
        if (bus.Enable_VQ && (bus.Opcode != OP_NOP)) begin
          sub_d   = (bus.Opcode == OP_SUB);
          vj_d    = bus.Vj;
          vk_d    = bus.Vk;
          qj_d    = bus.Qj;
          qk_d    = bus.Qk;
          // A broadcast on the capture edge must not be missed.
          if (bus.CDB_Valid && (bus.Qj != NO_TAG) && (bus.CDB_Tag == bus.Qj)) begin
            vj_d = bus.CDB_Data;
            qj_d = NO_TAG;
          end
          if (bus.CDB_Valid && (bus.Qk != NO_TAG) && (bus.CDB_Tag == bus.Qk)) begin
            vk_d = bus.CDB_Data;
            qk_d = NO_TAG;
          end
          ready_d = 1'b0;
          busy_d  = 1'b1;
          if ((qj_d == NO_TAG) && (qk_d == NO_TAG)) begin
            state_d = EXEC;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = WAIT_OPS;
          end
        end
      end

      WAIT_OPS: begin
        if (bus.CDB_Valid && (qj_q != NO_TAG) && (bus.CDB_Tag == qj_q)) begin
          vj_d = bus.CDB_Data;
          qj_d = NO_TAG;
        end
        if (bus.CDB_Valid && (qk_q != NO_TAG) && (bus.CDB_Tag == qk_q)) begin
          vk_d = bus.CDB_Data;
          qk_d = NO_TAG;
        end
        if ((qj_d == NO_TAG) && (qk_d == NO_TAG)) begin
          state_d = EXEC;
          cnt_d   = CNT_LOAD;
        end
      end

      EXEC: begin
        if (cnt_q == 3'd0) begin
          state_d  = WB;
          rvalid_d = 1'b1;
          rtag_d   = STATION_TAG;
          rdata_d  = sub_q ? (vj_q - vk_q) : (vj_q + vk_q);
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      WB: begin
        if (bus.Result_Grant) begin
          state_d  = IDLE;
          ready_d  = 1'b1;
          busy_d   = 1'b0;
          rvalid_d = 1'b0;
          rtag_d   = NO_TAG;
          rdata_d  = NO_VALUE;
          vj_d     = NO_VALUE;
          vk_d     = NO_VALUE;
          qj_d     = NO_TAG;
          qk_d     = NO_TAG;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any op in flight.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      sub_q    <= 1'b0;
      vj_q     <= NO_VALUE;
      vk_q     <= NO_VALUE;
      qj_q     <= NO_TAG;
      qk_q     <= NO_TAG;
      cnt_q    <= 3'd0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rtag_q   <= NO_TAG;
      rdata_q  <= NO_VALUE;
    end else begin
      state_q  <= state_d;
      sub_q    <= sub_d;
      vj_q     <= vj_d;
      vk_q     <= vk_d;
      qj_q     <= qj_d;
      qk_q     <= qk_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      rvalid_q <= rvalid_d;
      rtag_q   <= rtag_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.Ready        = ready_q;
  assign bus.Busy         = busy_q;
  assign bus.Result_Valid = rvalid_q;
  assign bus.Result_Tag   = rtag_q;
  assign bus.Result_Data  = rdata_q;

endmodule

// File: tb/tb_reservation_station_add.sv
// Directed bench for the ADD/SUB reservation station (tag 1, latency 2).
module tb_reservation_station_add;

  logic Clock;
  logic Reset;
  int   total;
  int   passed;

  reservation_station_add_if rs ();

  reservation_station_add #(
    .STATION_TAG (3'd1),
    .EXEC_LATENCY(2),
    .NO_TAG      (3'd0),
    .NO_VALUE    (16'hFFF0)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (rs.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic dispatch(input logic [2:0] op, input logic [15:0] vj, input logic [15:0] vk,
                          input logic [2:0] qj, input logic [2:0] qk);
    rs.Enable_VQ = 1'b1;
    rs.Opcode    = op;
    rs.Vj        = vj;
    rs.Vk        = vk;
    rs.Qj        = qj;
    rs.Qk        = qk;
  endtask

  task automatic cdb(input logic v, input logic [2:0] t, input logic [15:0] d);
    rs.CDB_Valid = v;
    rs.CDB_Tag   = t;
    rs.CDB_Data  = d;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    Reset  = 1'b1;
    rs.Enable_VQ    = 1'b0;
    rs.Opcode       = 3'd0;
    rs.Vj           = 16'd0;
    rs.Vk           = 16'd0;
    rs.Qj           = 3'd0;
    rs.Qk           = 3'd0;
    rs.Result_Grant = 1'b0;
    cdb(1'b0, 3'd0, 16'd0);

    // Reset values
    #12;
    check("rst_ready", 16'(rs.Ready), 16'd1);
    check("rst_busy", 16'(rs.Busy), 16'd0);
    check("rst_rvalid", 16'(rs.Result_Valid), 16'd0);
    check("rst_rtag", 16'(rs.Result_Tag), 16'd0);
    check("rst_rdata", rs.Result_Data, 16'hFFF0);
    Reset = 1'b0;
    tick();

    // NOP with enable is ignored
    dispatch(3'b000, 16'd1, 16'd1, 3'd0, 3'd0);
    tick();
    check("nop_ready", 16'(rs.Ready), 16'd1);
    rs.Enable_VQ = 1'b0;

    // Simple ADD 5+7, grant already high
    rs.Result_Grant = 1'b1;
    dispatch(3'b001, 16'd5, 16'd7, 3'd0, 3'd0);
    tick();
    rs.Enable_VQ = 1'b0;
    check("add_ready0", 16'(rs.Ready), 16'd0);
    check("add_busy1", 16'(rs.Busy), 16'd1);
    check("add_rv_c1", 16'(rs.Result_Valid), 16'd0);
    tick();
    check("add_rv_c2", 16'(rs.Result_Valid), 16'd0);
    tick();
    check("add_rv", 16'(rs.Result_Valid), 16'd1);
    check("add_data", rs.Result_Data, 16'd12);
    check("add_tag", 16'(rs.Result_Tag), 16'd1);
    tick();
    check("add_rv_off", 16'(rs.Result_Valid), 16'd0);
    check("add_ready1", 16'(rs.Ready), 16'd1);
    check("add_data_idle", rs.Result_Data, 16'hFFF0);
    check("add_tag_idle", 16'(rs.Result_Tag), 16'd0);
    rs.Result_Grant = 1'b0;

    // SUB with Vj pending on tag 2, broadcast arrives three cycles later
    dispatch(3'b010, 16'd0, 16'd3, 3'd2, 3'd0);
    tick();
    rs.Enable_VQ = 1'b0;
    tick();
    tick();
    check("sub_wait_busy", 16'(rs.Busy), 16'd1);
    check("sub_wait_rv", 16'(rs.Result_Valid), 16'd0);
    cdb(1'b1, 3'd2, 16'h0010);
    tick();
    cdb(1'b0, 3'd0, 16'd0);
    check("sub_rv_c1", 16'(rs.Result_Valid), 16'd0);
    tick();
    check("sub_rv_c2", 16'(rs.Result_Valid), 16'd0);
    tick();
    check("sub_rv", 16'(rs.Result_Valid), 16'd1);
    check("sub_data", rs.Result_Data, 16'h000D);
    rs.Result_Grant = 1'b1;
    tick();
    rs.Result_Grant = 1'b0;
    check("sub_ready1", 16'(rs.Ready), 16'd1);

    // Both operands on tag 2; foreign tag 3 broadcast must be ignored
    dispatch(3'b001, 16'd0, 16'd0, 3'd2, 3'd2);
    tick();
    rs.Enable_VQ = 1'b0;
    cdb(1'b1, 3'd3, 16'h1234);
    tick();
    cdb(1'b1, 3'd2, 16'h0021);
    tick();
    cdb(1'b0, 3'd0, 16'd0);
    check("dual_rv_c1", 16'(rs.Result_Valid), 16'd0);
    tick();
    check("dual_rv_c2", 16'(rs.Result_Valid), 16'd0);
    tick();
    check("dual_rv", 16'(rs.Result_Valid), 16'd1);
    check("dual_data", rs.Result_Data, 16'h0042);
    rs.Result_Grant = 1'b1;
    tick();
    rs.Result_Grant = 1'b0;

    // Broadcast on the capture edge satisfies Qj without a stall
    dispatch(3'b001, 16'd0, 16'd1, 3'd2, 3'd0);
    cdb(1'b1, 3'd2, 16'd9);
    tick();
    rs.Enable_VQ = 1'b0;
    cdb(1'b0, 3'd0, 16'd0);
    tick();
    check("snoop_rv_c1", 16'(rs.Result_Valid), 16'd0);
    tick();
    check("snoop_rv", 16'(rs.Result_Valid), 16'd1);
    check("snoop_data", rs.Result_Data, 16'd10);
    rs.Result_Grant = 1'b1;
    tick();
    rs.Result_Grant = 1'b0;

    // Wrap-around ADD, grant withheld 4 cycles while dispatch keeps enabling
    dispatch(3'b001, 16'hFFFF, 16'h0001, 3'd0, 3'd0);
    tick();
    rs.Enable_VQ = 1'b0;
    tick();
    tick();
    check("wrap_rv", 16'(rs.Result_Valid), 16'd1);
    check("wrap_data", rs.Result_Data, 16'h0000);
    dispatch(3'b001, 16'd3, 16'd4, 3'd0, 3'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_rv", 16'(rs.Result_Valid), 16'd1);
      check("hold_data", rs.Result_Data, 16'h0000);
      check("hold_tag", 16'(rs.Result_Tag), 16'd1);
    end
    rs.Result_Grant = 1'b1;
    tick();
    rs.Result_Grant = 1'b0;
    check("grant_edge_ready", 16'(rs.Ready), 16'd1);
    check("grant_edge_rv", 16'(rs.Result_Valid), 16'd0);
    tick();
    rs.Enable_VQ = 1'b0;
    check("post_grant_cap", 16'(rs.Ready), 16'd0);
    tick();
    tick();
    check("post_grant_rv", 16'(rs.Result_Valid), 16'd1);
    check("post_grant_data", rs.Result_Data, 16'd7);
    rs.Result_Grant = 1'b1;
    tick();
    rs.Result_Grant = 1'b0;

    // Asynchronous reset while waiting on an operand
    dispatch(3'b001, 16'd0, 16'd2, 3'd3, 3'd0);
    tick();
    rs.Enable_VQ = 1'b0;
    check("wait_ready0", 16'(rs.Ready), 16'd0);
    #2;
    Reset = 1'b1;
    #1;
    check("async_ready", 16'(rs.Ready), 16'd1);
    check("async_busy", 16'(rs.Busy), 16'd0);
    check("async_rv", 16'(rs.Result_Valid), 16'd0);
    check("async_data", rs.Result_Data, 16'hFFF0);
    #1;
    Reset = 1'b0;
    cdb(1'b1, 3'd3, 16'd5);
    tick();
    cdb(1'b0, 3'd0, 16'd0);
    tick();
    tick();
    check("after_rst_rv", 16'(rs.Result_Valid), 16'd0);
    check("after_rst_ready", 16'(rs.Ready), 16'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
